booth_mant_mul: RTL and testbench

Sequential radix-2 Booth multiplier for the unsigned significands (hidden bit plus fraction) of the FP8 (E4M3) datapath. It sits directly upstream of the FP8 multiply's normalise/round/exponent stage and produces the raw significand product that stage consumes. It replaces a combinational `operand_a * operand_b` with an iterative add/subtract-shift datapath. Operands and results move through valid/ready handshakes.

---
 rtl/booth_mant_mul_if.sv | 26 ++
 rtl/booth_mant_mul.sv | 101 ++++++++++
 tb/tb_booth_mant_mul.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/booth_mant_mul_if.sv
// Operand/result handshake bundle for the FP8 significand Booth multiplier.
// The multiplier is the slave; the upstream/downstream logic is the master.
interface booth_mant_mul_if #(
    parameter int MWIDTH = 3
);
    localparam int N = MWIDTH + 1;

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, product, busy
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_mant_mul.sv
// Sequential radix-2 Booth multiplier for unsigned E4M3 significands.
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one add/sub + arithmetic shift per cycle, N+1 steps
// DONE  | product valid, held until out_ready
module booth_mant_mul #(
    parameter int MWIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mant_mul_if.slave    bus
);
    localparam int N  = MWIDTH + 1;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N+1:0]   r_a;
    logic [N+1:0]   r_m;
    logic [N:0]     r_q;
    logic           r_qm1;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;

    logic [N+1:0]   w_a_sum;
    logic [N+1:0]   w_a_sh;
    logic [N:0]     w_q_sh;
    logic           w_zero;
    logic           w_last;

    assign w_zero = (bus.op_a == '0) || (bus.op_b == '0);
    assign w_last = (r_cnt == CW'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_a_sum = r_a + r_m;
            2'b10:   w_a_sum = r_a - r_m;
            default: w_a_sum = r_a;
        endcase
    end

    // {A, Q, q_m1} shifted right by one with A's sign replicated
    assign w_a_sh = {w_a_sum[N+1], w_a_sum[N+1:1]};
    assign w_q_sh = {w_a_sum[0], r_q[N:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_m   <= {2'b00, bus.op_a};
                        r_a   <= '0;
                        r_q   <= {1'b0, bus.op_b};
                        r_qm1 <= 1'b0;
                        r_cnt <= '0;
                        if (w_zero) r_product <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_sh;
                    r_q   <= w_q_sh;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    // upper bits of {A, Q} are zero for unsigned operands
                    if (w_last) r_product <= {w_a_sh[N-2:0], w_q_sh};
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.product   = r_product;
endmodule

// File: tb/tb_booth_mant_mul.sv
// Directed and sweep checks for booth_mant_mul at MWIDTH=3.
module tb_booth_mant_mul;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    booth_mant_mul_if #(.MWIDTH(3)) bus_if ();

    booth_mant_mul #(.MWIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is counted in clock edges after the accept edge at which
    // out_valid is first seen high.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input int exp_lat);
        int lat;
        @(negedge clk);
        bus_if.in_valid  = 1'b1;
        bus_if.op_a      = a;
        bus_if.op_b      = b;
        bus_if.out_ready = 1'b1;
        chk({tag, "_in_ready_pre"}, 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk({tag, "_in_ready_post"}, 32'(bus_if.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_product"}, 32'(bus_if.product), 32'(exp_p));
        @(negedge clk);
        chk({tag, "_in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
        chk({tag, "_out_valid_drop"}, 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int highs;
        int idx;
        int gap;
        int accepts;
        int results;
        int cycles;
        logic [7:0] exp_q[$];
        logic [7:0] exp_p;

        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_busy",      32'(bus_if.busy),      32'd0);
        chk("rst_product",   32'(bus_if.product),   32'd0);
        rst_n = 1'b1;

        run_op("ff",    4'hF, 4'hF, 8'hE1, 5);
        run_op("a_5",   4'hA, 4'h5, 8'h32, 5);
        run_op("8_f",   4'h8, 4'hF, 8'h78, 5);
        run_op("zero_b", 4'h9, 4'h0, 8'h00, 0);
        run_op("zero_a", 4'h0, 4'hF, 8'h00, 0);

        // backpressure on 0xB * 0xD
        @(negedge clk);
        bus_if.in_valid  = 1'b1;
        bus_if.op_a      = 4'hB;
        bus_if.op_b      = 4'hD;
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            bus_if.in_valid = i[0];
            bus_if.op_a     = 4'($urandom_range(1, 15));
            bus_if.op_b     = 4'($urandom_range(1, 15));
            @(negedge clk);
            chk("bp_product",   32'(bus_if.product),   32'h8F);
            chk("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus_if.in_ready),  32'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus_if.in_ready),  32'd1);
        chk("bp_release_prod",  32'(bus_if.product),   32'h8F);
        highs = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.out_valid) highs++;
        end
        chk("bp_single_consume", 32'(highs), 32'd0);

        // async reset in the third RUN cycle of 0xF * 0xF
        bus_if.in_valid = 1'b1;
        bus_if.op_a     = 4'hF;
        bus_if.op_b     = 4'hF;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(bus_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_rst_busy",      32'(bus_if.busy),      32'd0);
        chk("mid_rst_product",   32'(bus_if.product),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.out_valid) highs++;
        end
        chk("mid_rst_no_result", 32'(highs), 32'd0);
        run_op("after_rst", 4'h3, 4'h7, 8'h15, 5);

        // exhaustive sweep with random gaps on both sides
        idx     = 0;
        gap     = 0;
        accepts = 0;
        results = 0;
        cycles  = 0;
        while ((idx < 256 || exp_q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            if (idx < 256 && gap == 0) begin
                bus_if.in_valid = 1'b1;
                bus_if.op_a     = idx[7:4];
                bus_if.op_b     = idx[3:0];
            end else begin
                bus_if.in_valid = 1'b0;
                if (gap > 0) gap--;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                exp_p = 8'(idx[7:4] * idx[3:0]);
                exp_q.push_back(exp_p);
                accepts++;
                idx++;
                gap = $urandom_range(0, 2);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                results++;
                if (exp_q.size() == 0) chk("sweep_unexpected", 32'(bus_if.product), 32'hFFFF_FFFF);
                else                   chk("sweep_product", 32'(bus_if.product), 32'(exp_q.pop_front()));
            end
        end
        bus_if.in_valid = 1'b0;
        chk("sweep_timeout", 32'(cycles < 20000), 32'd1);
        chk("sweep_accepts", 32'(accepts), 32'd256);
        chk("sweep_results", 32'(results), 32'(accepts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
